// File: rtl/strip_cluster_sequencer.sv
// Strip cluster sequencer: walks a latched 128-strip hit map from the highest
// strip downwards and hands out one cluster word per accepted handshake.
// A cluster word is the address of the highest remaining hit plus the three
// strips directly below it. Each accepted word removes its 4-strip window from
// the map, so no strip is ever reported twice.
module strip_cluster_sequencer #(
  parameter int unsigned MAX_CLUSTERS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         clus_valid_o,
  input  logic         clus_ready_i,
  output logic [6:0]   clus_addr_o,
  output logic [2:0]   clus_next_o,
  output logic         event_done_o,
  output logic         overflow_o
);

  localparam int unsigned CntW = $clog2(MAX_CLUSTERS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_CLUSTERS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e          state_q;
  logic [127:0]    map_q;
  logic [CntW-1:0] cnt_q;
  logic            ovf_q;

  logic [6:0]      p;
  logic [2:0]      next_bits;
  logic [127:0]    map_cleared;
  logic            map_empty;
  logic            accept;

  // Priority encoder: index of the highest set bit of the map.
  always_comb begin
    p = '0;
    for (int i = 0; i < 128; i++) begin
      if (map_q[i]) begin
        p = 7'(i);
      end
    end
  end

  // The three strips below p; indices below 0 read as 0.
  always_comb begin
    next_bits = '0;
    for (int k = 1; k <= 3; k++) begin
      if (int'(p) >= k) begin
        next_bits[3-k] = map_q[int'(p) - k];
      end
    end
  end

  // Map with the window p..p-3 removed, whatever those bits held.
  always_comb begin
    map_cleared = map_q;
    for (int i = 0; i < 128; i++) begin
      if ((i <= int'(p)) && (i + 3 >= int'(p))) begin
        map_cleared[i] = 1'b0;
      end
    end
  end

  assign map_empty = (map_q == '0);
  assign accept    = (state_q == StScan) && !map_empty && clus_ready_i;

  // Sequencer FSM together with the hit map, cluster count and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      map_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            map_q   <= data_i;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (map_empty) begin
            ovf_q   <= 1'b0;
            state_q <= StDone;
          end else if (accept) begin
            map_q <= map_cleared;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              ovf_q   <= (map_cleared != '0);
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decoded from registers; address/pattern forced to 0 when not valid.
  always_comb begin
    busy_o       = (state_q != StIdle);
    clus_valid_o = (state_q == StScan) && !map_empty;
    clus_addr_o  = clus_valid_o ? p : 7'd0;
    clus_next_o  = clus_valid_o ? next_bits : 3'd0;
    event_done_o = (state_q == StDone);
    overflow_o   = event_done_o && ovf_q;
  end

endmodule
